// File: rtl/dmem_slave.sv
// dmem_slave: single-outstanding data-memory slave for the RV32 load/store port.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, executes in a single
// access cycle, and then presents a registered response until it is consumed.
// Define DMEM_ERR_CHECK_EN to fault misaligned, out-of-range and reserved-funct3
// requests. Without it, addresses wrap, lanes are force-aligned and reserved
// codes act as LW/SW.
module dmem_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  // Latched request; never reset, only meaningful once a request is accepted.
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        f3_q;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  size_t             size;
  logic              exec;
  logic              fault;
  logic              mem_we;
  logic [3:0]        wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ld_data_d;

  // Access width from funct3; reserved codes fall through to word.
  function automatic size_t decode_size(input logic we, input logic [2:0] f3);
    size_t sz;
    if (we) begin
      case (f3)
        3'b000:  sz = SZ_B;
        3'b001:  sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: sz = SZ_B;
        3'b001, 3'b101: sz = SZ_H;
        default:        sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  // Extract the addressed lane(s) and sign/zero extend to a full word.
  function automatic logic [DATA_W-1:0] extend_load(input size_t sz, input logic sgn,
                                                    input logic [DATA_W-1:0] word,
                                                    input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [DATA_W-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_B:    r = sgn ? {{24{b[7]}}, b} : {24'b0, b};
      SZ_H:    r = sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Word index drops the byte-lane bits; any higher bits are range-checked or ignored.
  assign idx     = addr_q[IDX_W+1:2];
  assign size    = decode_size(we_q, f3_q);
  // The WAIT cycle whose count has run down to zero is the one access cycle.
  assign exec    = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign rd_word = mem_q[idx];
  assign ld_data_d = extend_load(size, ~f3_q[2], rd_word, addr_q[1:0]);

`ifdef DMEM_ERR_CHECK_EN
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH_WORDS * 4);

  function automatic logic is_reserved(input logic we, input logic [2:0] f3);
    if (we) return f3 > 3'b010;
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  logic misalign;
  logic oob;
  assign misalign = ((size == SZ_H) && addr_q[0]) ||
                    ((size == SZ_W) && (addr_q[1:0] != 2'b00));
  assign oob      = ({1'b0, addr_q} >= ADDR_LIMIT);
  assign fault    = misalign || oob || is_reserved(we_q, f3_q);
`else
  // Upper address bits are deliberately dropped so the array aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[ADDR_W-1:IDX_W+2];
  assign fault = 1'b0;
`endif

  // Byte-enable and lane-replicated write data for the store width.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = wdata_q;
    case (size)
      SZ_B: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  // A reset landing on the access cycle must abort the write.
  assign mem_we = exec && we_q && !fault && !rst;

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Request/response FSM with all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            f3_q        <= req_funct3;
            cnt_q       <= 4'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= fault;
            rsp_rdata_q <= (fault || we_q) ? '0 : ld_data_d;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_slave.sv
// tb_dmem_slave: directed vector table plus hand-written hold and reset sequences.
module tb_dmem_slave;

  localparam int W = 1;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, input logic [31:0] er, input logic ee);
    vec_t v;
    v = '{we, addr, wdata, f3, er, ee};
    vecs.push_back(v);
  endtask

  // Issue one request from posedge+1; returns when the response is seen
  // (and consumed if rsp_ready is high). lat counts edges from accept to rsp_valid.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                         output int lat, output logic ok);
    int waited;
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    req_valid = 1'b1;
    waited = 0;
    lat = 0; rdata = '0; err = 1'b0; ok = 1'b0;
    while (!req_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    ok = rsp_valid; rdata = rsp_rdata; err = rsp_err;
    if (rsp_ready && ok) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        ok;
    int          lat;

    // Directed vectors: {we, addr, wdata, funct3, expected rdata, expected err}
    add(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
    add(0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0);
    add(1, 32'h10, 32'h0,        3'b010, 32'h0, 0);
    add(1, 32'h13, 32'h00000080, 3'b000, 32'h0, 0);
    add(0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 0);
    add(0, 32'h13, 32'h0,        3'b100, 32'h00000080, 0);
    add(0, 32'h10, 32'h0,        3'b010, 32'h80000000, 0);
    add(1, 32'h20, 32'h1122C344, 3'b010, 32'h0, 0);
    add(1, 32'h22, 32'hABCD8001, 3'b001, 32'h0, 0);
    add(0, 32'h22, 32'h0,        3'b001, 32'hFFFF8001, 0);
    add(0, 32'h22, 32'h0,        3'b101, 32'h00008001, 0);
    add(0, 32'h20, 32'h0,        3'b001, 32'hFFFFC344, 0);
    add(0, 32'h20, 32'h0,        3'b010, 32'h8001C344, 0);
    add(1, 32'h21, 32'hFFFFFFA5, 3'b000, 32'h0, 0);
    add(0, 32'h20, 32'h0,        3'b010, 32'h8001A544, 0);
    add(0, 32'h22, 32'h0,        3'b100, 32'h00000001, 0);
    add(0, 32'h23, 32'h0,        3'b000, 32'hFFFFFF80, 0);
    add(1, 32'h0,  32'hCAFEF00D, 3'b010, 32'h0, 0);
    add(0, 32'h2,  32'h0,        3'b010, ERR ? 32'h0 : 32'hCAFEF00D, ERR);
    add(0, 32'h21, 32'h0,        3'b001, ERR ? 32'h0 : 32'hFFFFA544, ERR);
    add(0, 32'h1000, 32'h0,      3'b010, ERR ? 32'h0 : 32'hCAFEF00D, ERR);
    add(0, 32'h0,  32'h0,        3'b011, ERR ? 32'h0 : 32'hCAFEF00D, ERR);
    add(1, 32'h4,  32'h0,        3'b010, 32'h0, 0);
    add(1, 32'h4,  32'h99AABBCC, 3'b101, 32'h0, ERR);
    add(0, 32'h4,  32'h0,        3'b010, ERR ? 32'h0 : 32'h99AABBCC, 0);
    add(1, 32'h2,  32'h55667788, 3'b010, 32'h0, ERR);
    add(0, 32'h0,  32'h0,        3'b010, ERR ? 32'hCAFEF00D : 32'h55667788, 0);

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err",   32'(rsp_err), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset req_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er, lat, ok);
      chk($sformatf("vec%0d handshake", i), 32'(ok), 32'h1);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(W + 1));
    end

    // Backpressure: response must hold steady while rsp_ready is low.
    rsp_ready = 1'b0;
    run_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, ok);
    chk("hold handshake", 32'(ok), 32'h1);
    chk("hold rdata", rd, 32'h80000000);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d rsp_valid", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("hold%0d rsp_rdata", c), rsp_rdata, 32'h80000000);
      chk($sformatf("hold%0d req_ready", c), 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold release rsp_valid", 32'(rsp_valid), 32'h0);
    chk("hold release req_ready", 32'(req_ready), 32'h1);

    // Reset during WAIT must abort the pending store.
    run_req(1'b1, 32'h0, 32'h0, 3'b010, rd, er, lat, ok);
    chk("preload handshake", 32'(ok), 32'h1);
    run_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, ok);
    chk("rdata before abort", rd, 32'h80000000);
    req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    req_valid = 1'b1;
    chk("abort req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort rsp_rdata", rsp_rdata, 32'h0);
    chk("abort rsp_err",   32'(rsp_err), 32'h0);
    chk("abort req_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort recover req_ready", 32'(req_ready), 32'h1);
    run_req(1'b0, 32'h0, 32'h0, 3'b010, rd, er, lat, ok);
    chk("abort readback handshake", 32'(ok), 32'h1);
    chk("abort readback rdata", rd, 32'h0);
    chk("abort readback err", 32'(er), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
